// File: rtl/countdown_mmss.sv
// ============================================================================
// countdown_mmss : four-digit mm:ss BCD countdown timer with 1 s prescaler
// Revision: 1.0
// ============================================================================
`default_nettype none

module countdown_mmss #(
    parameter  int TICK_DIV = 50_000_000,
    localparam int PW       = $clog2(TICK_DIV)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] s,
    input  logic       load,
    input  logic [2:0] ld_m_tens,
    input  logic [3:0] ld_m_ones,
    input  logic [2:0] ld_s_tens,
    input  logic [3:0] ld_s_ones,
    output logic [2:0] m_tens,
    output logic [3:0] m_ones,
    output logic [2:0] s_tens,
    output logic [3:0] s_ones,
    output logic       running,
    output logic       expired,
    output logic       done
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_CLEAR = 2'b10;

    localparam logic [PW-1:0] PSC_MAX = PW'(TICK_DIV - 1);

    logic [1:0]    state_q,   state_d;
    logic [PW-1:0] psc_q,     psc_d;
    logic [2:0]    m_tens_q,  m_tens_d;
    logic [3:0]    m_ones_q,  m_ones_d;
    logic [2:0]    s_tens_q,  s_tens_d;
    logic [3:0]    s_ones_q,  s_ones_d;
    logic          running_q, expired_q, done_q, done_d;

    logic [2:0]    dec_m_tens;
    logic [3:0]    dec_m_ones;
    logic [2:0]    dec_s_tens;
    logic [3:0]    dec_s_ones;
    logic          count_nz;
    logic          last_sec;

    function automatic logic [2:0] clamp_tens(input logic [2:0] v);
        return (v > 3'd5) ? 3'd5 : v;
    endfunction

    function automatic logic [3:0] clamp_ones(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    assign count_nz = (m_tens_q != 3'd0) || (m_ones_q != 4'd0) ||
                      (s_tens_q != 3'd0) || (s_ones_q != 4'd0);
    assign last_sec = (m_tens_q == 3'd0) && (m_ones_q == 4'd0) &&
                      (s_tens_q == 3'd0) && (s_ones_q == 4'd1);

    // One-second decrement with borrow; only used while the count is nonzero.
    always_comb begin
        dec_m_tens = m_tens_q;
        dec_m_ones = m_ones_q;
        dec_s_tens = s_tens_q;
        dec_s_ones = s_ones_q;
        if (s_ones_q != 4'd0) begin
            dec_s_ones = s_ones_q - 4'd1;
        end else begin
            dec_s_ones = 4'd9;
            if (s_tens_q != 3'd0) begin
                dec_s_tens = s_tens_q - 3'd1;
            end else begin
                dec_s_tens = 3'd5;
                if (m_ones_q != 4'd0) begin
                    dec_m_ones = m_ones_q - 4'd1;
                end else begin
                    dec_m_ones = 4'd9;
                    if (m_tens_q != 3'd0) begin
                        dec_m_tens = m_tens_q - 3'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        psc_d    = psc_q;
        m_tens_d = m_tens_q;
        m_ones_d = m_ones_q;
        s_tens_d = s_tens_q;
        s_ones_d = s_ones_q;
        done_d   = 1'b0;
        if (load) begin
            m_tens_d = clamp_tens(ld_m_tens);
            m_ones_d = clamp_ones(ld_m_ones);
            s_tens_d = clamp_tens(ld_s_tens);
            s_ones_d = clamp_ones(ld_s_ones);
            psc_d    = '0;
            state_d  = ST_IDLE;
        end else if (s == S_CLEAR) begin
            m_tens_d = 3'd0;
            m_ones_d = 4'd0;
            s_tens_d = 3'd0;
            s_ones_d = 4'd0;
            psc_d    = '0;
            state_d  = ST_IDLE;
        end else if (s == S_RUN) begin
            case (state_q)
                ST_IDLE, ST_PAUSED: begin
                    // The entry edge only changes state; counting starts next cycle.
                    if (count_nz) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (psc_q == PSC_MAX) begin
                        psc_d    = '0;
                        m_tens_d = dec_m_tens;
                        m_ones_d = dec_m_ones;
                        s_tens_d = dec_s_tens;
                        s_ones_d = dec_s_ones;
                        if (last_sec) begin
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end
                    end else begin
                        psc_d = psc_q + PW'(1);
                    end
                end
                default: begin
                end
            endcase
        end else if (state_q == ST_RUN) begin
            state_d = ST_PAUSED;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            psc_q     <= '0;
            m_tens_q  <= 3'd0;
            m_ones_q  <= 4'd0;
            s_tens_q  <= 3'd0;
            s_ones_q  <= 4'd0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            psc_q     <= psc_d;
            m_tens_q  <= m_tens_d;
            m_ones_q  <= m_ones_d;
            s_tens_q  <= s_tens_d;
            s_ones_q  <= s_ones_d;
            running_q <= (state_d == ST_RUN);
            expired_q <= (state_d == ST_EXPIRED);
            done_q    <= done_d;
        end
    end

    assign m_tens  = m_tens_q;
    assign m_ones  = m_ones_q;
    assign s_tens  = s_tens_q;
    assign s_ones  = s_ones_q;
    assign running = running_q;
    assign expired = expired_q;
    assign done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_countdown_mmss.sv
// ============================================================================
// tb_countdown_mmss : directed vector table plus random run against a
//                     seconds-based reference model of the countdown timer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_countdown_mmss;

    localparam int TD = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] s = 2'b00;
    logic       load = 1'b0;
    logic [2:0] ld_m_tens = '0;
    logic [3:0] ld_m_ones = '0;
    logic [2:0] ld_s_tens = '0;
    logic [3:0] ld_s_ones = '0;
    logic [2:0] m_tens;
    logic [3:0] m_ones;
    logic [2:0] s_tens;
    logic [3:0] s_ones;
    logic       running, expired, done;

    countdown_mmss #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .reset     (reset),
        .s         (s),
        .load      (load),
        .ld_m_tens (ld_m_tens),
        .ld_m_ones (ld_m_ones),
        .ld_s_tens (ld_s_tens),
        .ld_s_ones (ld_s_ones),
        .m_tens    (m_tens),
        .m_ones    (m_ones),
        .s_tens    (s_tens),
        .s_ones    (s_ones),
        .running   (running),
        .expired   (expired),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [1:0] sm;
        int         mt, mo, st, so;
        int         n;
        int         e_secs;
        logic       e_run, e_exp, e_done;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: remaining time in plain seconds
    int   m_secs, m_psc, m_state;
    logic m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int clampv(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [13:0] digits_of(input int secs);
        logic [2:0] a; logic [3:0] b; logic [2:0] c; logic [3:0] d;
        a = 3'(secs / 600);
        b = 4'((secs / 60) % 10);
        c = 3'((secs % 60) / 10);
        d = 4'(secs % 10);
        return {a, b, c, d};
    endfunction

    function automatic logic [16:0] dut_out();
        return {m_tens, m_ones, s_tens, s_ones, running, expired, done};
    endfunction

    function automatic logic [16:0] model_out();
        return {digits_of(m_secs), (m_state == M_RUN), (m_state == M_EXP), m_done};
    endfunction

    task automatic model_reset();
        m_secs = 0; m_psc = 0; m_state = M_IDLE; m_done = 1'b0;
    endtask

    task automatic model_step();
        m_done = 1'b0;
        if (load) begin
            m_secs = clampv(int'(ld_m_tens), 5) * 600 + clampv(int'(ld_m_ones), 9) * 60 +
                     clampv(int'(ld_s_tens), 5) * 10  + clampv(int'(ld_s_ones), 9);
            m_psc = 0; m_state = M_IDLE;
        end else if (s == 2'b10) begin
            m_secs = 0; m_psc = 0; m_state = M_IDLE;
        end else if (s == 2'b01) begin
            if ((m_state == M_IDLE || m_state == M_PAUSED) && m_secs > 0) begin
                m_state = M_RUN;
            end else if (m_state == M_RUN) begin
                m_psc++;
                if (m_psc == TD) begin
                    m_psc = 0;
                    m_secs--;
                    if (m_secs == 0) begin
                        m_state = M_EXP;
                        m_done  = 1'b1;
                    end
                end
            end
        end else if (m_state == M_RUN) begin
            m_state = M_PAUSED;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("model", 32'(dut_out()), 32'(model_out()));
    endtask

    function automatic vec_t mk(input logic ld, input logic [1:0] sm, input int mt, input int mo,
                                input int st, input int so, input int n, input int e_secs,
                                input logic e_run, input logic e_exp, input logic e_done);
        vec_t v;
        v.ld = ld; v.sm = sm; v.mt = mt; v.mo = mo; v.st = st; v.so = so; v.n = n;
        v.e_secs = e_secs; v.e_run = e_run; v.e_exp = e_exp; v.e_done = e_done;
        return v;
    endfunction

    initial begin
        // load 01:00, run: 00:59 four clocks after RUN is entered
        vecs.push_back(mk(1, 2'b00, 0, 1, 0, 0,  1,  60, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  1,  60, 1, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  3,  60, 1, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  1,  59, 1, 0, 0));
        // load 00:02 (load beats RUN), run to expiry
        vecs.push_back(mk(1, 2'b01, 0, 0, 0, 2,  1,   2, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  1,   2, 1, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  4,   1, 1, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  3,   1, 1, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  1,   0, 0, 1, 1));
        vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  1,   0, 0, 1, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0, 20,   0, 0, 1, 0));
        // pause mid-second and resume the partial second
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 0,  1,  10, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  1,  10, 1, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  4,   9, 1, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  2,   9, 1, 0, 0));
        vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 10,   9, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  1,   9, 1, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  1,   9, 1, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  1,   8, 1, 0, 0));
        // clamped load wins over CLEAR, then one tick
        vecs.push_back(mk(1, 2'b10, 7, 15, 7, 15, 1, 3599, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  1, 3599, 1, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  4, 3598, 1, 0, 0));
        // CLEAR, then RUN on a zero count stays IDLE
        vecs.push_back(mk(0, 2'b10, 0, 0, 0, 0,  1,   0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0, 20,   0, 0, 0, 0));

        model_reset();
        #1 reset = 1'b0;
        #2;
        chk("reset_outputs", 32'(dut_out()), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            load = vecs[i].ld; s = vecs[i].sm;
            ld_m_tens = 3'(vecs[i].mt); ld_m_ones = 4'(vecs[i].mo);
            ld_s_tens = 3'(vecs[i].st); ld_s_ones = 4'(vecs[i].so);
            for (int k = 0; k < vecs[i].n; k++) begin
                cycle();
                load = 1'b0;
            end
            chk($sformatf("vec%0d", i), 32'(dut_out()),
                32'({digits_of(vecs[i].e_secs), vecs[i].e_run, vecs[i].e_exp, vecs[i].e_done}));
        end

        // asynchronous reset between edges while running
        load = 1'b1; s = 2'b00; ld_m_tens = 3'd0; ld_m_ones = 4'd0; ld_s_tens = 3'd3; ld_s_ones = 4'd0;
        cycle();
        load = 1'b0; s = 2'b01;
        repeat (6) cycle();
        chk("pre_reset_running", 32'(running), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async_reset", 32'(dut_out()), 32'd0);
        model_reset();
        #1 reset = 1'b1;
        repeat (20) cycle();
        chk("post_reset_idle", 32'(dut_out()), 32'd0);

        // randomized traffic biased towards short counts so expiry happens often
        for (int k = 0; k < 600; k++) begin
            int r;
            load = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 0) begin
                ld_m_tens = 3'd0; ld_m_ones = 4'd0; ld_s_tens = 3'd0;
                ld_s_ones = 4'($urandom_range(0, 15));
            end else begin
                ld_m_tens = 3'($urandom_range(0, 7)); ld_m_ones = 4'($urandom_range(0, 15));
                ld_s_tens = 3'($urandom_range(0, 7)); ld_s_ones = 4'($urandom_range(0, 15));
            end
            r = $urandom_range(0, 31);
            s = (r < 26) ? 2'b01 : (r < 29) ? 2'b00 : (r < 30) ? 2'b11 : 2'b10;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
